// File: rtl/hms_clock_core.sv
// hms_clock_core
// Time-of-day core: 24 h hours/minutes/seconds with a RUN/SET mode driven
// by three single-cycle button pulses. Feeds the digit split / FND display
// path with binary time values and a per-digit blank mask for blinking the
// field under edit.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   i_mode   pulse: toggle RUN/SET
//   i_pos    pulse: advance edited field (SET only)
//   i_up     pulse: increment edited field (SET only)
//   o_sec    seconds 0..59
//   o_min    minutes 0..59
//   o_hour   hours 0..23
//   o_mode   current state (0 = RUN, 1 = SET), also the FSM debug view
//   o_pos    edited field (0 = sec, 1 = min, 2 = hour)
//   o_blank  per-digit blank mask, [1:0] sec, [3:2] min, [5:4] hour
//   o_tick   one-cycle pulse per counted second
//
// Handshake: the three button inputs are strobes with no ready; a pulse is
// consumed on the edge it is sampled. Priority i_mode > i_pos > i_up.
// Every output is a register; nothing combinational reaches an output.
module hms_clock_core #(
  parameter int TICK_NUM  = 50000000,
  parameter int BLINK_NUM = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_mode,
  input  logic       i_pos,
  input  logic       i_up,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_mode,
  output logic [1:0] o_pos,
  output logic [5:0] o_blank,
  output logic       o_tick
);

  localparam int TW = $clog2(TICK_NUM);
  localparam int BW = $clog2(BLINK_NUM);
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_NUM - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_NUM - 1);
  localparam logic [BW-1:0] BLINK_ONE = BW'(1);
  localparam logic S_RUN = 1'b0;
  localparam logic S_SET = 1'b1;

  logic          r_state, w_state;
  logic [5:0]    r_sec, w_sec;
  logic [5:0]    r_min, w_min;
  logic [4:0]    r_hour, w_hour;
  logic [1:0]    r_pos, w_pos;
  logic [5:0]    r_blank, w_blank;
  logic          r_tick, w_tick;
  logic [TW-1:0] r_tick_cnt, w_tick_cnt;
  logic [BW-1:0] r_blink_cnt, w_blink_cnt;
  logic          r_phase, w_phase;

  // State register (also holds every datapath/output register).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_sec       <= '0;
      r_min       <= '0;
      r_hour      <= '0;
      r_pos       <= '0;
      r_blank     <= '0;
      r_tick      <= 1'b0;
      r_tick_cnt  <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sec       <= w_sec;
      r_min       <= w_min;
      r_hour      <= w_hour;
      r_pos       <= w_pos;
      r_blank     <= w_blank;
      r_tick      <= w_tick;
      r_tick_cnt  <= w_tick_cnt;
      r_blink_cnt <= w_blink_cnt;
      r_phase     <= w_phase;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state = r_state;
    if (i_mode) w_state = ~r_state;
  end

  // Output / datapath next values.
  always_comb begin
    w_sec       = r_sec;
    w_min       = r_min;
    w_hour      = r_hour;
    w_pos       = r_pos;
    w_tick      = 1'b0;
    w_tick_cnt  = r_tick_cnt;
    w_blink_cnt = r_blink_cnt;
    w_phase     = r_phase;
    w_blank     = '0;

    if (r_state == S_RUN) begin
      if (r_tick_cnt == TICK_MAX) begin
        w_tick_cnt = '0;
        w_tick     = 1'b1;
        if (r_sec == 6'd59) begin
          w_sec = 6'd0;
          if (r_min == 6'd59) begin
            w_min  = 6'd0;
            w_hour = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
          end else begin
            w_min = r_min + 6'd1;
          end
        end else begin
          w_sec = r_sec + 6'd1;
        end
      end else begin
        w_tick_cnt = r_tick_cnt + TICK_ONE;
      end
      // A tick on the same edge as entry to SET is still applied above;
      // only the divider and edit state are re-armed here.
      if (i_mode) begin
        w_tick_cnt  = '0;
        w_pos       = 2'd0;
        w_blink_cnt = '0;
        w_phase     = 1'b0;
      end
    end else begin
      // Divider parked at 0 so the first tick after exit is a full second.
      w_tick_cnt = '0;
      if (i_mode) begin
        w_blink_cnt = '0;
        w_phase     = 1'b0;
      end else if (i_pos) begin
        w_pos       = (r_pos == 2'd2) ? 2'd0 : r_pos + 2'd1;
        w_blink_cnt = '0;
        w_phase     = 1'b0;
      end else begin
        if (r_blink_cnt == BLINK_MAX) begin
          w_blink_cnt = '0;
          w_phase     = ~r_phase;
        end else begin
          w_blink_cnt = r_blink_cnt + BLINK_ONE;
        end
        if (i_up) begin
          case (r_pos)
            2'd0:    w_sec  = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
            2'd1:    w_min  = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
            2'd2:    w_hour = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
            default: ;
          endcase
        end
      end
    end

    // Blank mask is built from next-cycle values so it lines up with them.
    if (w_state == S_SET && w_phase) begin
      case (w_pos)
        2'd0:    w_blank = 6'b000011;
        2'd1:    w_blank = 6'b001100;
        2'd2:    w_blank = 6'b110000;
        default: w_blank = 6'b000000;
      endcase
    end
  end

  assign o_sec   = r_sec;
  assign o_min   = r_min;
  assign o_hour  = r_hour;
  assign o_mode  = r_state;
  assign o_pos   = r_pos;
  assign o_blank = r_blank;
  assign o_tick  = r_tick;

endmodule

// File: tb/tb_hms_clock_core.sv
module tb_hms_clock_core;

  localparam int TICK  = 10;
  localparam int BLINK = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_mode = 1'b0, i_pos = 1'b0, i_up = 1'b0;
  logic [5:0] o_sec, o_min, o_blank;
  logic [4:0] o_hour;
  logic       o_mode, o_tick;
  logic [1:0] o_pos;

  always #5 clk = ~clk;

  hms_clock_core #(.TICK_NUM(TICK), .BLINK_NUM(BLINK)) dut (
    .clk(clk), .rst_n(rst_n), .i_mode(i_mode), .i_pos(i_pos), .i_up(i_up),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_mode(o_mode),
    .o_pos(o_pos), .o_blank(o_blank), .o_tick(o_tick)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard ----------------
  // Packed {sec, min, hour, mode, pos, blank, tick}.
  logic [26:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] dut_vec();
    return {o_sec, o_min, o_hour, o_mode, o_pos, o_blank, o_tick};
  endfunction

  // ---------------- reference model ----------------
  // Behavioural: seconds counted down to the next tick, blink counted 1..BLINK.
  int       m_sec, m_min, m_hour, m_pos, m_left, m_bcnt;
  bit       m_mode, m_phase, m_tick;

  task automatic m_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_pos = 0; m_bcnt = 0;
    m_mode = 0; m_phase = 0; m_tick = 0; m_left = TICK;
  endtask

  function automatic logic [26:0] m_vec();
    logic [5:0] blank;
    blank = 6'b0;
    if (m_mode && m_phase) blank = (m_pos == 0) ? 6'b000011 : (m_pos == 1) ? 6'b001100 : 6'b110000;
    return {6'(m_sec), 6'(m_min), 5'(m_hour), m_mode, 2'(m_pos), blank, m_tick};
  endfunction

  task automatic m_step(input bit md, input bit ps, input bit up);
    m_tick = 0;
    if (!m_mode) begin
      m_left--;
      if (m_left == 0) begin
        m_tick = 1;
        m_left = TICK;
        m_sec  = (m_sec + 1) % 60;
        if (m_sec == 0) begin
          m_min = (m_min + 1) % 60;
          if (m_min == 0) m_hour = (m_hour + 1) % 24;
        end
      end
      if (md) begin m_mode = 1; m_pos = 0; m_bcnt = 0; m_phase = 0; end
    end else begin
      if (md) begin
        m_mode = 0; m_left = TICK; m_bcnt = 0; m_phase = 0;
      end else if (ps) begin
        m_pos = (m_pos + 1) % 3; m_bcnt = 0; m_phase = 0;
      end else begin
        m_bcnt++;
        if (m_bcnt == BLINK) begin m_bcnt = 0; m_phase = ~m_phase; end
        if (up) begin
          if (m_pos == 0) m_sec = (m_sec + 1) % 60;
          else if (m_pos == 1) m_min = (m_min + 1) % 60;
          else m_hour = (m_hour + 1) % 24;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // One clock: drive pulses, push expected, sample #1 after the edge, pop/compare.
  task automatic step(input bit md, input bit ps, input bit up);
    logic [26:0] e;
    i_mode = md; i_pos = ps; i_up = up;
    m_step(md, ps, up);
    exp_q.push_back(m_vec());
    @(posedge clk);
    #1;
    i_mode = 0; i_pos = 0; i_up = 0;
    if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      check("cycle", 32'(dut_vec()), 32'(e));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0);
  endtask

  task automatic ups(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1);
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic hard_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  int n_tick;

  initial begin
    m_reset();
    // Reset state
    #12;
    check("reset_state", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. 1 Hz tick every TICK cycles
    for (int c = 1; c <= 30; c++) begin
      step(0, 0, 0);
      if (c % 10 == 0) begin
        check("tick_pulse", 32'(o_tick), 32'd1);
        check("tick_sec", 32'(o_sec), 32'(c / 10));
        check("run_mode_blank", 32'({o_mode, o_blank}), 32'd0);
      end
    end
    // i_up / i_pos ignored in RUN
    step(0, 0, 1);
    step(0, 1, 0);
    check("run_ignore", 32'({o_sec, o_pos}), 32'({6'd3, 2'd0}));

    // 2. Preload 23:59:58 and roll over
    hard_reset();
    step(1, 0, 0);
    ups(58); step(0, 1, 0);
    ups(59); step(0, 1, 0);
    ups(23);
    check("preload", 32'({o_hour, o_min, o_sec}), 32'({5'd23, 6'd59, 6'd58}));
    step(1, 0, 0);
    idle(TICK);
    check("t_235959", 32'({o_hour, o_min, o_sec, o_tick}), 32'({5'd23, 6'd59, 6'd59, 1'b1}));
    idle(TICK);
    check("t_000000", 32'({o_hour, o_min, o_sec, o_tick}), 32'({5'd0, 6'd0, 6'd0, 1'b1}));

    // 3. Hour wrap in SET
    hard_reset();
    step(1, 0, 0); step(0, 1, 0); step(0, 1, 0);
    ups(25);
    check("set_hour_wrap", 32'({o_mode, o_pos, o_hour, o_min, o_sec, o_tick}),
          32'({1'b1, 2'd2, 5'd1, 6'd0, 6'd0, 1'b0}));

    // 4. Blink on minutes, then move to hours
    hard_reset();
    step(1, 0, 0); step(0, 1, 0);
    check("blink_min_0", 32'(o_blank), 32'b000000);
    idle(3);
    check("blink_min_1", 32'(o_blank), 32'b001100);
    idle(3);
    check("blink_min_2", 32'(o_blank), 32'b000000);
    idle(3);
    step(0, 1, 0);
    check("blink_pos_clr", 32'(o_blank), 32'b000000);
    idle(3);
    check("blink_hour", 32'(o_blank), 32'b110000);

    // 5. Same-cycle pulses
    hard_reset();
    step(1, 0, 1);
    check("mode_up", 32'({o_mode, o_sec}), 32'({1'b1, 6'd0}));
    step(0, 1, 1);
    check("pos_up", 32'({o_pos, o_min, o_sec}), 32'({2'd1, 6'd0, 6'd0}));
    step(1, 1, 1);
    check("mode_pos_up", 32'({o_mode, o_pos, o_min}), 32'({1'b0, 2'd1, 6'd0}));

    // 6. Async reset mid-SET at 12:34:56, then first tick timing
    hard_reset();
    step(1, 0, 0);
    ups(56); step(0, 1, 0);
    ups(34); step(0, 1, 0);
    ups(12);
    check("at_123456", 32'({o_hour, o_min, o_sec}), 32'({5'd12, 6'd34, 6'd56}));
    hard_reset();
    n_tick = 0;
    for (int c = 1; c <= 3 * TICK; c++) begin
      step(0, 0, 0);
      if (o_tick && n_tick == 0) n_tick = c;
    end
    check("first_tick_after_reset", 32'(n_tick), 32'(TICK));
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
